// File: rtl/rggen_native_arbiter_pkg.sv
// Shared types for the native CSR bus arbiter slice: access kinds, response
// status codes and the grant-index width helper.
package rggen_native_arbiter_pkg;

  typedef enum logic [1:0] {
    RGGEN_READ         = 2'b00,
    RGGEN_WRITE        = 2'b01,
    RGGEN_POSTED_WRITE = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  // Index width for a host count; a two-host arbiter still needs one bit.
  function automatic int idx_width(input int hosts);
    return (hosts <= 2) ? 1 : $clog2(hosts);
  endfunction

endpackage

// File: rtl/rggen_native_arbiter_if.sv
// Native-protocol CSR bus. The master holds valid and the request payload
// until a one-cycle ready; status and read_data are meaningful in that cycle.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int STROBE_WIDTH  = BUS_WIDTH / 8
);
  import rggen_native_arbiter_pkg::*;

  logic                     valid;
  rggen_access              access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [STROBE_WIDTH-1:0]  strobe;
  logic                     ready;
  rggen_status              status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );

endinterface

// File: rtl/rggen_native_arbiter_select.sv
// Winner selection for the native arbiter. Default build: round-robin scan
// starting at ptr_i. With RGGEN_NATIVE_ARBITER_FIXED_PRIORITY_EN defined the
// lowest-indexed requester wins and the pointer input does not exist.
module rggen_native_arbiter_select #(
  parameter int HOSTS = 2,
  parameter int IDX_W = 1
) (
`ifndef RGGEN_NATIVE_ARBITER_FIXED_PRIORITY_EN
  input  logic [IDX_W-1:0] ptr_i,
`endif
  input  logic [HOSTS-1:0] req_i,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  // First requester found scanning upward (from the pointer, wrapping, or from 0).
  always_comb begin
    int   idx;
    logic found;
    idx         = 0;
    found       = 1'b0;
    grant_idx_o = '0;
    for (int k = 0; k < HOSTS; k++) begin
`ifdef RGGEN_NATIVE_ARBITER_FIXED_PRIORITY_EN
      idx = k;
`else
      idx = (int'(ptr_i) + k) % HOSTS;
`endif
      if (!found && req_i[idx[IDX_W-1:0]]) begin
        found       = 1'b1;
        grant_idx_o = idx[IDX_W-1:0];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/rggen_native_arbiter.sv
// Serialises several native CSR hosts onto one downstream native bus.
// Requests are registered on grant; responses route back combinationally
// to the granted host. Build option: RGGEN_NATIVE_ARBITER_FIXED_PRIORITY_EN
// selects fixed priority (host 0 highest) instead of round-robin.
//
// state   | meaning
// IDLE    | no downstream request; arbitrate among valid hosts
// BUSY    | registered request on csrbus_if, waiting for ready
module rggen_native_arbiter
  import rggen_native_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int STROBE_WIDTH  = BUS_WIDTH / 8,
  parameter int HOSTS         = 2
) (
  input logic         i_clk,
  input logic         i_rst_n,
  rggen_bus_if.slave  host_if [HOSTS],
  rggen_bus_if.master csrbus_if
);

  localparam int IDX_W = idx_width(HOSTS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]               state_q,   state_d;
  logic [IDX_W-1:0]         grant_q,   grant_d;
  rggen_access              access_q,  access_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [BUS_WIDTH-1:0]     wdata_q,   wdata_d;
  logic [STROBE_WIDTH-1:0]  strobe_q,  strobe_d;

  logic [HOSTS-1:0]         req;
  logic [IDX_W-1:0]         sel_idx;
  logic                     sel_any;
  logic                     done;

  rggen_access              host_access  [HOSTS];
  logic [ADDRESS_WIDTH-1:0] host_address [HOSTS];
  logic [BUS_WIDTH-1:0]     host_wdata   [HOSTS];
  logic [STROBE_WIDTH-1:0]  host_strobe  [HOSTS];

  assign done = (state_q == ST_BUSY) && csrbus_if.ready;

  for (genvar g = 0; g < HOSTS; g++) begin : g_host
    logic granted;
    assign granted           = done && (grant_q == IDX_W'(g));
    assign req[g]            = host_if[g].valid;
    assign host_access[g]    = host_if[g].access;
    assign host_address[g]   = host_if[g].address;
    assign host_wdata[g]     = host_if[g].write_data;
    assign host_strobe[g]    = host_if[g].strobe;
    assign host_if[g].ready     = granted;
    assign host_if[g].status    = granted ? csrbus_if.status : RGGEN_OKAY;
    assign host_if[g].read_data = granted ? csrbus_if.read_data : '0;
  end

`ifdef RGGEN_NATIVE_ARBITER_FIXED_PRIORITY_EN
  rggen_native_arbiter_select #(
    .HOSTS (HOSTS),
    .IDX_W (IDX_W)
  ) u_select (
    .req_i       (req),
    .grant_idx_o (sel_idx),
    .any_o       (sel_any)
  );
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  rggen_native_arbiter_select #(
    .HOSTS (HOSTS),
    .IDX_W (IDX_W)
  ) u_select (
    .ptr_i       (ptr_q),
    .req_i       (req),
    .grant_idx_o (sel_idx),
    .any_o       (sel_any)
  );

  // Pointer advances past the served host only when its transaction completes.
  always_comb begin
    ptr_d = ptr_q;
    if (done) begin
      ptr_d = (grant_q == IDX_W'(HOSTS - 1)) ? '0 : grant_q + IDX_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`endif

  // Grant and capture the winner's payload in IDLE; release on downstream ready.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    access_d  = access_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    strobe_d  = strobe_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          state_d   = ST_BUSY;
          grant_d   = sel_idx;
          access_d  = host_access[sel_idx];
          address_d = host_address[sel_idx];
          wdata_d   = host_wdata[sel_idx];
          strobe_d  = host_strobe[sel_idx];
        end
      end
      default: begin
        if (csrbus_if.ready) state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant and payload registers; reset also kills any in-flight request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      access_q  <= RGGEN_READ;
      address_q <= '0;
      wdata_q   <= '0;
      strobe_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      access_q  <= access_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      strobe_q  <= strobe_d;
    end
  end

  assign csrbus_if.valid      = (state_q == ST_BUSY);
  assign csrbus_if.access     = access_q;
  assign csrbus_if.address    = address_q;
  assign csrbus_if.write_data = wdata_q;
  assign csrbus_if.strobe     = strobe_q;

endmodule

// File: tb/tb_rggen_native_arbiter.sv
// Scoreboard bench for rggen_native_arbiter with three hosts. The stimulus
// process drives hosts and a downstream responder and, from the arbitration
// rules, pushes the expected downstream request and host response; a monitor
// process compares whatever the DUT presents against those queues.
module tb_rggen_native_arbiter;
  import rggen_native_arbiter_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int H  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .STROBE_WIDTH(SW)) host_bus [H] ();
  rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .STROBE_WIDTH(SW)) csr_bus ();

  rggen_native_arbiter #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (DW),
    .STROBE_WIDTH  (SW),
    .HOSTS         (H)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .host_if   (host_bus),
    .csrbus_if (csr_bus)
  );

  logic          h_valid  [H];
  logic [1:0]    h_access [H];
  logic [AW-1:0] h_addr   [H];
  logic [DW-1:0] h_wdata  [H];
  logic [SW-1:0] h_strobe [H];
  wire           h_ready  [H];
  wire [1:0]     h_status [H];
  wire [DW-1:0]  h_rdata  [H];

  logic          a_ready;
  logic [1:0]    a_status;
  logic [DW-1:0] a_rdata;

  for (genvar g = 0; g < H; g++) begin : g_host
    assign host_bus[g].valid      = h_valid[g];
    assign host_bus[g].access     = rggen_access'(h_access[g]);
    assign host_bus[g].address    = h_addr[g];
    assign host_bus[g].write_data = h_wdata[g];
    assign host_bus[g].strobe     = h_strobe[g];
    assign h_ready[g]             = host_bus[g].ready;
    assign h_status[g]            = host_bus[g].status;
    assign h_rdata[g]             = host_bus[g].read_data;
  end

  assign csr_bus.ready     = a_ready;
  assign csr_bus.status    = rggen_status'(a_status);
  assign csr_bus.read_data = a_rdata;

  typedef struct {
    int            host;
    logic [1:0]    access;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strobe;
  } req_t;

  typedef struct {
    int            host;
    logic [1:0]    status;
    logic [DW-1:0] rdata;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   served[$];
  int   ready_seen = 0;
  int   n_checks   = 0;
  int   n_fail     = 0;

  // reference model and stimulus controls
  int         m_ptr = 0;
  bit         m_busy = 0;
  int         m_winner = 0;
  int         wait_cnt = 0;
  bit         stall = 0;
  int         fixed_delay = -1;
  int         force_status = -1;
  bit         rd_seq = 0;
  int         rd_cnt = 0;
  bit         reads_only = 0;
  int         req_pct = 0;
  bit [H-1:0] host_en = '0;
  bit         active    [H];
  bit         saw_ready [H];
  bit         dir_pend  [H];
  req_t       dir_req   [H];
  logic [1:0] acc_tbl   [3] = '{2'b00, 2'b01, 2'b11};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int g, input logic [1:0] acc, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [SW-1:0] strobe);
    dir_pend[g]       = 1'b1;
    dir_req[g].host   = g;
    dir_req[g].access = acc;
    dir_req[g].addr   = addr;
    dir_req[g].wdata  = wdata;
    dir_req[g].strobe = strobe;
  endtask

  function automatic bit any_active();
    bit a = 0;
    for (int g = 0; g < H; g++) a |= active[g] | dir_pend[g];
    return a;
  endfunction

  // One clock of host behaviour, round-robin reference and downstream responder.
  task automatic step();
    int start, found;
    @(negedge clk);
    for (int g = 0; g < H; g++) begin
      if (saw_ready[g]) begin
        active[g]    = 0;
        h_valid[g]   = 1'b0;
        saw_ready[g] = 0;
      end
      if (!active[g] && dir_pend[g]) begin
        dir_pend[g] = 0;
        active[g]   = 1;
        h_valid[g]  = 1'b1;
        h_access[g] = dir_req[g].access;
        h_addr[g]   = dir_req[g].addr;
        h_wdata[g]  = dir_req[g].wdata;
        h_strobe[g] = dir_req[g].strobe;
      end else if (!active[g] && host_en[g] && $urandom_range(99) < req_pct) begin
        active[g]   = 1;
        h_valid[g]  = 1'b1;
        h_access[g] = reads_only ? 2'b00 : acc_tbl[$urandom_range(2)];
        h_addr[g]   = AW'($urandom);
        h_wdata[g]  = $urandom;
        h_strobe[g] = SW'($urandom_range(1, 15));
      end
    end
    a_ready  = 1'b0;
    a_status = 2'b00;
    a_rdata  = '0;
    if (!m_busy) begin
`ifdef RGGEN_NATIVE_ARBITER_FIXED_PRIORITY_EN
      start = 0;
`else
      start = m_ptr;
`endif
      found = -1;
      for (int k = 0; k < H; k++) begin
        if (found < 0 && h_valid[(start + k) % H]) found = (start + k) % H;
      end
      if (found >= 0) begin
        req_t r;
        r.host   = found;
        r.access = h_access[found];
        r.addr   = h_addr[found];
        r.wdata  = h_wdata[found];
        r.strobe = h_strobe[found];
        exp_req.push_back(r);
        m_winner = found;
        m_busy   = 1;
        wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(3));
      end
    end else if (!stall) begin
      if (wait_cnt == 0) begin
        rsp_t s;
        a_ready  = 1'b1;
        a_status = (force_status >= 0) ? force_status[1:0] : 2'($urandom_range(3));
        a_rdata  = rd_seq ? DW'(32'h11 * (rd_cnt + 1)) : DW'($urandom);
        rd_cnt++;
        s.host   = m_winner;
        s.status = a_status;
        s.rdata  = a_rdata;
        exp_rsp.push_back(s);
        m_ptr  = (m_winner + 1) % H;
        m_busy = 0;
      end else begin
        wait_cnt--;
      end
    end
    #1;
    for (int g = 0; g < H; g++) saw_ready[g] = h_ready[g];
  endtask

  task automatic drain();
    host_en = '0;
    for (int i = 0; i < 200 && (m_busy || any_active()); i++) step();
    check("drain_timeout", {63'd0, (m_busy || any_active())}, 0);
  endtask

  // Monitor: compare downstream requests and host responses with the queues.
  initial begin : monitor
    bit   prev_v = 0;
    bit   have_cur = 0;
    bit   any_rdy;
    req_t cur;
    rsp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_v   = 0;
        have_cur = 0;
      end else begin
        if (csr_bus.valid) begin
          if (!prev_v) begin
            n_checks++;
            if (exp_req.size() == 0) begin
              n_fail++;
              have_cur = 0;
              $display("FAIL unexpected_request: downstream valid=1, expected no request at %0t", $time);
            end else begin
              cur      = exp_req.pop_front();
              have_cur = 1;
            end
          end
          if (have_cur) begin
            check("req_access",  csr_bus.access,     cur.access);
            check("req_address", csr_bus.address,    cur.addr);
            check("req_wdata",   csr_bus.write_data, cur.wdata);
            check("req_strobe",  csr_bus.strobe,     cur.strobe);
          end
        end
        prev_v  = csr_bus.valid;
        any_rdy = 0;
        for (int g = 0; g < H; g++) begin
          if (h_ready[g]) begin
            any_rdy = 1;
            served.push_back(g);
            ready_seen++;
          end
        end
        if (exp_rsp.size() > 0) begin
          r = exp_rsp.pop_front();
          for (int g = 0; g < H; g++) begin
            if (g == r.host) begin
              check("rsp_ready",  h_ready[g],  1);
              check("rsp_status", h_status[g], r.status);
              check("rsp_rdata",  h_rdata[g],  r.rdata);
            end else begin
              check("other_ready",  h_ready[g],  0);
              check("other_status", h_status[g], RGGEN_OKAY);
              check("other_rdata",  h_rdata[g],  0);
            end
          end
        end else begin
          check("spurious_ready", {63'd0, any_rdy}, 0);
        end
      end
    end
  end

  initial begin : stimulus
    int base, first;
    int exp_order [3];
`ifdef RGGEN_NATIVE_ARBITER_FIXED_PRIORITY_EN
    exp_order = '{0, 0, 0};
`else
    exp_order = '{0, 1, 0};
`endif
    for (int g = 0; g < H; g++) begin
      h_valid[g] = 1'b0; h_access[g] = '0; h_addr[g] = '0; h_wdata[g] = '0; h_strobe[g] = '0;
      active[g] = 0; saw_ready[g] = 0; dir_pend[g] = 0;
    end
    a_ready = 1'b0; a_status = '0; a_rdata = '0;

    // reset values
    @(negedge clk);
    #1;
    check("rst_valid",  csr_bus.valid,      0);
    check("rst_access", csr_bus.access,     0);
    check("rst_addr",   csr_bus.address,    0);
    check("rst_wdata",  csr_bus.write_data, 0);
    check("rst_strobe", csr_bus.strobe,     0);
    for (int g = 0; g < H; g++) begin
      check("rst_host_ready",  h_ready[g],  0);
      check("rst_host_status", h_status[g], RGGEN_OKAY);
      check("rst_host_rdata",  h_rdata[g],  0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // simultaneous reads from hosts 0 and 1, responses 0x11, 0x22, ...
    base = served.size();
    host_en = 3'b011; req_pct = 100; reads_only = 1; rd_seq = 1; rd_cnt = 0;
    repeat (20) step();
    drain();
    reads_only = 0; rd_seq = 0;
    for (int i = 0; i < 3; i++) begin
      first = (served.size() > base + i) ? served[base + i] : -1;
      check("simul_order", first, exp_order[i]);
    end

    // single write from host 0, adapter answers after two wait cycles
    fixed_delay = 2; force_status = 0;
    set_req(0, 2'b01, 8'h10, 32'hDEADBEEF, 4'hF);
    step();
    @(posedge clk);
    #2;
    check("write_valid_next_cycle", csr_bus.valid,      1);
    check("write_addr",             csr_bus.address,    8'h10);
    check("write_data",             csr_bus.write_data, 32'hDEADBEEF);
    drain();
    first = (served.size() > 0) ? served[served.size() - 1] : -1;
    check("write_served_host", first, 0);

    // error status routed only to the granted host
    fixed_delay = -1; force_status = 2;
    host_en = 3'b011; req_pct = 100;
    repeat (15) step();
    drain();
    force_status = -1;

    // stalled downstream
    stall = 1;
    set_req(2, 2'b01, 8'hA4, 32'h0BAD_F00D, 4'h3);
    base = ready_seen;
    repeat (55) step();
    check("stall_valid_held", csr_bus.valid, 1);
    check("stall_no_ready",   ready_seen - base, 0);
    stall = 0;
    drain();

    // reset in BUSY
    stall = 1; host_en = 3'b001; req_pct = 100;
    for (int i = 0; i < 20 && !m_busy; i++) step();
    @(posedge clk);
    #2;
    check("busy_before_reset", csr_bus.valid, 1);
    rst_n = 1'b0;
    #1;
    check("reset_valid_async", csr_bus.valid,   0);
    check("reset_addr_clear",  csr_bus.address, 0);
    exp_req.delete(); exp_rsp.delete();
    m_busy = 0; m_ptr = 0; stall = 0; host_en = '0;
    a_ready = 1'b0;
    for (int g = 0; g < H; g++) begin
      h_valid[g] = 1'b0; active[g] = 0; saw_ready[g] = 0; dir_pend[g] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = served.size();
    host_en = 3'b011; req_pct = 100;
    repeat (12) step();
    drain();
    first = (served.size() > base) ? served[base] : -1;
    check("first_after_reset", first, 0);

    // randomized traffic from all hosts
    host_en = 3'b111; req_pct = 40;
    repeat (1500) step();
    drain();

    repeat (3) @(negedge clk);
    check("req_queue_drained", exp_req.size(), 0);
    check("rsp_queue_drained", exp_rsp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
